change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Coin-output counterpart of the vending machine's coin-input path.
- Accepts a change amount in cents and pays it out greedily as one-cycle nickel, dime and quarter pulses on QOut/DOut/NOut, mirroring the N/D/Q input pulses the vending FSM consumes.
- Tracks per-denomination coin inventory, supports refill, and flags a shortfall when inventory cannot cover the amount.
- Sits between the vending FSM's change output and the coin-ejector solenoid drivers.

Parameters:
- PULSE_GAP, 2, idle cycles between consecutive coin pulses (>=1).
- INV_W, 4, width of each inventory counter.
- INIT_Q, 15, quarter count loaded on reset/refill.
- INIT_D, 15, dime count loaded on reset/refill.
- INIT_N, 15, nickel count loaded on reset/refill.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst  input  1  synchronous, active-high reset.
- ChangeValid  input  1  change request valid.
- ChangeAmt  input  6  change amount in cents, 0..63.
- ChangeReady  output  1  high when a request can be accepted.
- Refill  input  1  reload all inventory counters to INIT_*.
- QOut  output  1  one-cycle quarter eject pulse.
- DOut  output  1  one-cycle dime eject pulse.
- NOut  output  1  one-cycle nickel eject pulse.
- Busy  output  1  dispensing in progress.
- Done  output  1  one-cycle completion pulse.
- Short  output  1  valid with Done: amount not fully paid.
- Remaining  output  6  cents still owed; holds after Done.

Behaviour:
- Reset (Rst=1 at a rising edge): state IDLE; QOut, DOut, NOut, Busy, Done and Short = 0; Remaining = 0; ChangeReady = 1; inventories = INIT_*. Applies mid-dispense: pending coins are abandoned.
- States: IDLE, SELECT, PULSE, GAP, DONE.
  - IDLE: ChangeReady=1, Busy=0. On an edge with ChangeValid=1, load Remaining=ChangeAmt and go to SELECT.
  - SELECT (1 cycle, Busy=1): greedy choice, evaluated in this order:
    - Remaining>=25 and quarter count>0 -> quarter.
    - else Remaining>=10 and dime count>0 -> dime.
    - else Remaining>=5 and nickel count>0 -> nickel.
    - else -> DONE.
    - The chosen denomination is registered and the FSM goes to PULSE.
  - PULSE (1 cycle): exactly one of QOut/DOut/NOut is high. At the exiting edge, Remaining is reduced by 25/10/5 and the matching inventory is decremented by 1. Next state is GAP.
  - GAP: all coin outputs low for PULSE_GAP cycles, then SELECT.
  - DONE (1 cycle): Done=1. Short=1 iff Remaining>=5. Next state is IDLE.
- Latency: the first coin pulse occurs 2 cycles after the accept edge. Pulse period is PULSE_GAP+2 cycles. For amount 0, Done is asserted 2 cycles after accept.
- Residue below 5 cents (amount not a multiple of 5) is not paid and does not set Short; Remaining shows the residue.
- ChangeValid while not IDLE is ignored, with ChangeReady=0; the request is not queued.
- Refill:
  - Honoured in any state at the next edge.
  - If Refill coincides with a PULSE decrement, Refill wins and the count becomes INIT_*.
  - Refill does not alter FSM state or Remaining.
- Inventory counters never wrap below 0; the SELECT guard prevents this.
- Remaining holds its final value through IDLE until the next accept; Short and Done are pulses only.
- At most one of QOut/DOut/NOut is high in any cycle.

Test Plan:
- Rst for 1 cycle -> all coin outputs 0, Busy=0, Done=0, ChangeReady=1, Remaining=0.
- ChangeAmt=40, ChangeValid for 1 cycle (PULSE_GAP=2) -> QOut, DOut, NOut pulses in that order, 4 cycles apart, first pulse 2 cycles after accept; Done=1, Short=0, Remaining=0; inventories 14/14/14.
- INIT_Q=1, ChangeAmt=55 -> one QOut, then three DOut; Done with Short=0; quarter count 0.
- INIT_N=0, ChangeAmt=5 -> no coin pulses; Done=1 and Short=1 two cycles after accept; Remaining=5. Then ChangeAmt=17 with Refill asserted first -> DOut, NOut; Short=0, Remaining=2.
- ChangeAmt=60 accepted; new ChangeValid/ChangeAmt=5 held during dispensing -> ignored, ChangeReady=0. Rst one cycle after the first QOut -> no further pulses, ChangeReady=1 next cycle, inventories back to INIT_*.
- Refill asserted on the same edge as a DOut PULSE exit -> dime count equals INIT_D, not INIT_D-1; dispensing continues normally.

Source files
------------

// File: rtl/change_dispenser.sv
// Greedy coin payout engine: converts a change amount into one-cycle quarter,
// dime and nickel eject pulses while tracking per-denomination inventory.
module change_dispenser #(
  parameter int PULSE_GAP = 2,
  parameter int INV_W     = 4,
  parameter int INIT_Q    = 15,
  parameter int INIT_D    = 15,
  parameter int INIT_N    = 15
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       ChangeValid,
  input  logic [5:0] ChangeAmt,
  output logic       ChangeReady,
  input  logic       Refill,
  output logic       QOut,
  output logic       DOut,
  output logic       NOut,
  output logic       Busy,
  output logic       Done,
  output logic       Short,
  output logic [5:0] Remaining
);

  localparam int GW = (PULSE_GAP > 1) ? $clog2(PULSE_GAP) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_PULSE  = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [1:0] COIN_Q = 2'd0;
  localparam logic [1:0] COIN_D = 2'd1;
  localparam logic [1:0] COIN_N = 2'd2;

  localparam logic [INV_W-1:0] INIT_Q_V = INV_W'(INIT_Q);
  localparam logic [INV_W-1:0] INIT_D_V = INV_W'(INIT_D);
  localparam logic [INV_W-1:0] INIT_N_V = INV_W'(INIT_N);
  localparam logic [GW-1:0]    GAP_LAST = GW'(PULSE_GAP - 1);

  logic [2:0]       state_q, state_d;
  logic [5:0]       remaining_q, remaining_d;
  logic [1:0]       coin_q, coin_d;
  logic [GW-1:0]    gapCnt_q, gapCnt_d;
  logic [INV_W-1:0] invQ_q, invQ_d;
  logic [INV_W-1:0] invD_q, invD_d;
  logic [INV_W-1:0] invN_q, invN_d;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    coin_d      = coin_q;
    gapCnt_d    = gapCnt_q;
    invQ_d      = invQ_q;
    invD_d      = invD_q;
    invN_d      = invN_q;

    case (state_q)
      S_IDLE: begin
        if (ChangeValid) begin
          remaining_d = ChangeAmt;
          state_d     = S_SELECT;
        end
      end
      // Nonzero-inventory guards keep the counters from ever wrapping.
      S_SELECT: begin
        if (remaining_q >= 6'd25 && invQ_q != '0) begin
          coin_d  = COIN_Q;
          state_d = S_PULSE;
        end else if (remaining_q >= 6'd10 && invD_q != '0) begin
          coin_d  = COIN_D;
          state_d = S_PULSE;
        end else if (remaining_q >= 6'd5 && invN_q != '0) begin
          coin_d  = COIN_N;
          state_d = S_PULSE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_PULSE: begin
        state_d  = S_GAP;
        gapCnt_d = GAP_LAST;
        case (coin_q)
          COIN_Q: begin
            remaining_d = remaining_q - 6'd25;
            invQ_d      = invQ_q - 1'b1;
          end
          COIN_D: begin
            remaining_d = remaining_q - 6'd10;
            invD_d      = invD_q - 1'b1;
          end
          COIN_N: begin
            remaining_d = remaining_q - 6'd5;
            invN_d      = invN_q - 1'b1;
          end
          default: ;
        endcase
      end
      S_GAP: begin
        if (gapCnt_q == '0) begin
          state_d = S_SELECT;
        end else begin
          gapCnt_d = gapCnt_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A refill overrides any same-edge decrement from a pulse.
    if (Refill) begin
      invQ_d = INIT_Q_V;
      invD_d = INIT_D_V;
      invN_d = INIT_N_V;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      coin_q      <= COIN_Q;
      gapCnt_q    <= '0;
      invQ_q      <= INIT_Q_V;
      invD_q      <= INIT_D_V;
      invN_q      <= INIT_N_V;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      coin_q      <= coin_d;
      gapCnt_q    <= gapCnt_d;
      invQ_q      <= invQ_d;
      invD_q      <= invD_d;
      invN_q      <= invN_d;
    end
  end

  assign ChangeReady = (state_q == S_IDLE);
  assign Busy        = (state_q != S_IDLE);
  assign QOut        = (state_q == S_PULSE) && (coin_q == COIN_Q);
  assign DOut        = (state_q == S_PULSE) && (coin_q == COIN_D);
  assign NOut        = (state_q == S_PULSE) && (coin_q == COIN_N);
  assign Done        = (state_q == S_DONE);
  assign Short       = (state_q == S_DONE) && (remaining_q >= 6'd5);
  assign Remaining   = remaining_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: a greedy payout plan per request predicts every
// output cycle by cycle, plus literal checks on key timing points.
module tb_change_dispenser;

  localparam int PULSE_GAP = 2;
  localparam int PERIOD    = PULSE_GAP + 2;
  localparam int INIT_Q    = 15;
  localparam int INIT_D    = 15;
  localparam int INIT_N    = 15;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       ChangeValid = 1'b0;
  logic [5:0] ChangeAmt = '0;
  logic       Refill = 1'b0;
  logic       ChangeReady, QOut, DOut, NOut, Busy, Done, Short;
  logic [5:0] Remaining;

  change_dispenser #(
    .PULSE_GAP(PULSE_GAP), .INV_W(4),
    .INIT_Q(INIT_Q), .INIT_D(INIT_D), .INIT_N(INIT_N)
  ) dut (
    .Clk(Clk), .Rst(Rst), .ChangeValid(ChangeValid), .ChangeAmt(ChangeAmt),
    .ChangeReady(ChangeReady), .Refill(Refill), .QOut(QOut), .DOut(DOut),
    .NOut(NOut), .Busy(Busy), .Done(Done), .Short(Short), .Remaining(Remaining)
  );

  always #5 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;
  bit checkEn = 1'b0;

  // Plan for the current request; coin i pulses at d=1+PERIOD*i, where d
  // counts edges since the accept edge, and is paid off one edge later.
  int edgeCnt = 0;
  int acceptEdge = 0;
  bit planActive = 1'b0;
  int planAmt = 0;
  int planCoins = 0;
  int doneD = 0;
  int finalRem = 0;
  bit shortExp = 1'b0;
  int coinVal[16];
  int invQ = INIT_Q;
  int invD = INIT_D;
  int invN = INIT_N;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  function automatic void buildPlan(input int amt);
    int rem;
    rem = amt;
    planCoins = 0;
    while (rem >= 5) begin
      if (rem >= 25 && invQ > 0) begin
        coinVal[planCoins] = 25; invQ--;
      end else if (rem >= 10 && invD > 0) begin
        coinVal[planCoins] = 10; invD--;
      end else if (invN > 0) begin
        coinVal[planCoins] = 5; invN--;
      end else begin
        break;
      end
      rem -= coinVal[planCoins];
      planCoins++;
    end
    planAmt    = amt;
    acceptEdge = edgeCnt;
    planActive = 1'b1;
    doneD      = PERIOD * planCoins + 1;
    finalRem   = rem;
    shortExp   = (rem >= 5);
  endfunction

  always @(posedge Clk) begin : modelB
    int d;
    bit idle;
    d = edgeCnt - acceptEdge;
    idle = !planActive || (d > doneD);
    edgeCnt++;
    if (Rst) begin
      planActive = 1'b0;
      invQ = INIT_Q; invD = INIT_D; invN = INIT_N;
    end else begin
      if (Refill) begin
        invQ = INIT_Q; invD = INIT_D; invN = INIT_N;
        if (planActive) begin
          for (int i = 0; i < planCoins; i++) begin
            if (acceptEdge + 2 + PERIOD * i > edgeCnt) begin
              if (coinVal[i] == 25) invQ--;
              else if (coinVal[i] == 10) invD--;
              else invN--;
            end
          end
        end
      end
      if (idle && ChangeValid) buildPlan(int'(ChangeAmt));
    end
  end

  always @(negedge Clk) begin : compareB
    int d, eQ, eD, eN, eBusy, eDone, eShort, eReady, eRem;
    if (checkEn) begin
      d = edgeCnt - acceptEdge;
      eQ = 0; eD = 0; eN = 0; eBusy = 0; eDone = 0; eShort = 0; eReady = 1; eRem = 0;
      if (planActive && d > doneD) begin
        eRem = finalRem;
      end else if (planActive) begin
        eBusy = 1; eReady = 0; eRem = planAmt;
        for (int i = 0; i < planCoins; i++) begin
          if (d >= 2 + PERIOD * i) eRem -= coinVal[i];
          if (d == 1 + PERIOD * i) begin
            if (coinVal[i] == 25) eQ = 1;
            else if (coinVal[i] == 10) eD = 1;
            else eN = 1;
          end
        end
        if (d == doneD) begin
          eDone = 1;
          eShort = int'(shortExp);
        end
      end
      checkOutput("QOut", int'(QOut), eQ);
      checkOutput("DOut", int'(DOut), eD);
      checkOutput("NOut", int'(NOut), eN);
      checkOutput("Busy", int'(Busy), eBusy);
      checkOutput("Done", int'(Done), eDone);
      checkOutput("Short", int'(Short), eShort);
      checkOutput("ChangeReady", int'(ChangeReady), eReady);
      checkOutput("Remaining", int'(Remaining), eRem);
    end
  end

  task automatic startRequest(input int amt);
    @(posedge Clk);
    #1 ChangeValid = 1'b1;
    ChangeAmt = 6'(amt);
    @(posedge Clk);
    #1 ChangeValid = 1'b0;
  endtask

  task automatic skipTo(input int target);
    @(negedge Clk);
    while (edgeCnt - acceptEdge < target) @(negedge Clk);
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while (Done !== 1'b1 && n < 200) begin
      @(negedge Clk);
      n++;
    end
    if (Done !== 1'b1) checkOutput("doneTimeout", 0, 1);
  endtask

  task automatic applyStimulus(input int amt);
    startRequest(amt);
    waitDone();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    checkEn = 1'b1;

    @(negedge Clk);
    checkOutput("rstReady", int'(ChangeReady), 1);
    checkOutput("rstBusy", int'(Busy), 0);
    checkOutput("rstDone", int'(Done), 0);
    checkOutput("rstRemaining", int'(Remaining), 0);
    checkOutput("rstCoins", int'({QOut, DOut, NOut}), 0);

    // 40c: quarter, dime, nickel at d=1,5,9; done at d=13
    startRequest(40);
    skipTo(1);  checkOutput("amt40Q", int'(QOut), 1);
    skipTo(5);  checkOutput("amt40D", int'(DOut), 1);
    skipTo(9);  checkOutput("amt40N", int'(NOut), 1);
    skipTo(13);
    checkOutput("amt40Done", int'(Done), 1);
    checkOutput("amt40Short", int'(Short), 0);
    checkOutput("amt40Rem", int'(Remaining), 0);

    // Drain quarters down to one, then 55c uses the last quarter plus three dimes
    repeat (6) applyStimulus(50);
    applyStimulus(25);
    startRequest(55);
    skipTo(1);  checkOutput("amt55Q", int'(QOut), 1);
    skipTo(5);  checkOutput("amt55D1", int'(DOut), 1);
    skipTo(13); checkOutput("amt55D3", int'(DOut), 1);
    skipTo(17);
    checkOutput("amt55Done", int'(Done), 1);
    checkOutput("amt55Short", int'(Short), 0);
    checkOutput("amt55Rem", int'(Remaining), 0);
    startRequest(25);
    skipTo(1);
    checkOutput("qEmptyQ", int'(QOut), 0);
    checkOutput("qEmptyD", int'(DOut), 1);
    waitDone();

    // Drain nickels, then 5c cannot be paid
    repeat (13) applyStimulus(5);
    startRequest(5);
    skipTo(1);
    checkOutput("nEmptyDone", int'(Done), 1);
    checkOutput("nEmptyShort", int'(Short), 1);
    checkOutput("nEmptyRem", int'(Remaining), 5);
    checkOutput("nEmptyN", int'(NOut), 0);
    repeat (2) @(negedge Clk);
    checkOutput("remHold", int'(Remaining), 5);

    @(posedge Clk); #1 Refill = 1'b1;
    @(posedge Clk); #1 Refill = 1'b0;
    startRequest(17);
    skipTo(1); checkOutput("amt17D", int'(DOut), 1);
    skipTo(5); checkOutput("amt17N", int'(NOut), 1);
    skipTo(9);
    checkOutput("amt17Done", int'(Done), 1);
    checkOutput("amt17Short", int'(Short), 0);
    checkOutput("amt17Rem", int'(Remaining), 2);

    startRequest(0);
    skipTo(1);
    checkOutput("amt0Done", int'(Done), 1);
    checkOutput("amt0Short", int'(Short), 0);
    applyStimulus(63);

    // Request held during dispensing is ignored; reset abandons the payout
    startRequest(60);
    ChangeValid = 1'b1;
    ChangeAmt = 6'd5;
    skipTo(1); checkOutput("amt60Q", int'(QOut), 1);
    skipTo(2); checkOutput("busyReady", int'(ChangeReady), 0);
    Rst = 1'b1;
    ChangeValid = 1'b0;
    @(posedge Clk); #1 Rst = 1'b0;
    @(negedge Clk);
    checkOutput("midRstReady", int'(ChangeReady), 1);
    checkOutput("midRstRem", int'(Remaining), 0);
    repeat (6) @(negedge Clk);

    // Refill on the edge a dime is paid: dime count ends at INIT_D, then one more dime goes
    startRequest(45);
    skipTo(5);
    checkOutput("refillDOut", int'(DOut), 1);
    Refill = 1'b1;
    @(posedge Clk); #1 Refill = 1'b0;
    waitDone();
    repeat (14) applyStimulus(10);
    startRequest(10);
    skipTo(1);
    checkOutput("dEmptyD", int'(DOut), 0);
    checkOutput("dEmptyN1", int'(NOut), 1);
    skipTo(5);
    checkOutput("dEmptyN2", int'(NOut), 1);
    waitDone();

    repeat (3) @(negedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
